lif_neuron: RTL and testbench

LIF_NEURON -- requirements
Module: lif_neuron

---
 rtl/lif_neuron_if.sv | 73 +++++++
 rtl/lif_neuron.sv | 161 ++++++++++++++++
 tb/tb_lif_neuron.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/lif_neuron_if.sv
// -----------------------------------------------------------------------------
// lif_neuron_if
//   Bundles the per-neuron stimulus, configuration and result signals of a
//   leaky integrate-and-fire neuron so that a driver and the neuron core can be
//   connected with a single port.
//
// Parameters
//   SYNAPSES        number of binary synapse inputs
//   THRESHOLD_BITS  unsigned threshold width; membrane width is THRESHOLD_BITS+4
//
// Signals (direction seen from the neuron, i.e. the slave modport)
//   enable            in   1 = membrane integrates this cycle, 0 = membrane holds
//   inputs            in   spike inputs, 1 = active synapse
//   weights           in   per-synapse weight, 1 = +1, 0 = -1
//   batchnorm_factor  in   unsigned scale, 2 = unity gain
//   batchnorm_addend  in   two's-complement addend (-8..+7)
//   shift             in   leak shift amount, 0 = no leak
//   threshold         in   unsigned firing threshold
//   is_spike          out  fire flag (membrane >= threshold)
//   spike_posedge     out  one-cycle pulse on a rising is_spike
//   spike_negedge     out  one-cycle pulse on a falling is_spike
//   membrane          out  signed membrane potential
//
// Modports
//   master  drives stimulus/configuration, observes results
//   slave   the neuron core
// -----------------------------------------------------------------------------
interface lif_neuron_if #(
  parameter int SYNAPSES       = 16,
  parameter int THRESHOLD_BITS = 5
);
  localparam int M = THRESHOLD_BITS + 4;

  logic                        enable;
  logic [SYNAPSES-1:0]         inputs;
  logic [SYNAPSES-1:0]         weights;
  logic [3:0]                  batchnorm_factor;
  logic [3:0]                  batchnorm_addend;
  logic [2:0]                  shift;
  logic [THRESHOLD_BITS-1:0]   threshold;
  logic                        is_spike;
  logic                        spike_posedge;
  logic                        spike_negedge;
  logic signed [M-1:0]         membrane;

  modport master (
    output enable,
    output inputs,
    output weights,
    output batchnorm_factor,
    output batchnorm_addend,
    output shift,
    output threshold,
    input  is_spike,
    input  spike_posedge,
    input  spike_negedge,
    input  membrane
  );

  modport slave (
    input  enable,
    input  inputs,
    input  weights,
    input  batchnorm_factor,
    input  batchnorm_addend,
    input  shift,
    input  threshold,
    output is_spike,
    output spike_posedge,
    output spike_negedge,
    output membrane
  );
endinterface

// File: rtl/lif_neuron.sv
// -----------------------------------------------------------------------------
// lif_neuron
//   Leaky integrate-and-fire neuron with binary (+1/-1) synapse weights, a
//   batch-norm style scale/offset on the weighted input sum, shift-based leak
//   and reset-by-subtraction on firing.
//
//   Each enabled clock:
//     sum    = sum over active synapses of (+1 if weight=1 else -1)
//     bn     = ((sum * batchnorm_factor) >>> 1) + addend
//     u_next = u - (shift ? u >>> shift : 0) - (is_spike ? threshold : 0) + bn
//   u_next is formed at a width that cannot overflow and is then fitted back
//   to the membrane width M = THRESHOLD_BITS+4.
//
// Configuration macro
//   LIF_SATURATE_EN  defined:   u_next clamps to [-2^(M-1), 2^(M-1)-1]
//                    undefined: u_next wraps (two's-complement truncation)
//
// Parameters
//   SYNAPSES               number of binary synapse inputs (default 16)
//   THRESHOLD_BITS         unsigned threshold width (default 5)
//   BATCHNORM_ADDEND_BITS  internal width of the sign-extended addend (>= 4)
//
// Ports
//   clk    in  sole clock, rising edge
//   reset  in  synchronous active-high reset (membrane and edge history to 0)
//   nrn    lif_neuron_if.slave: stimulus/configuration in, spike flags and
//          membrane potential out
// -----------------------------------------------------------------------------
module lif_neuron #(
  parameter int SYNAPSES              = 16,
  parameter int THRESHOLD_BITS        = 5,
  parameter int BATCHNORM_ADDEND_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  lif_neuron_if.slave nrn
);

  localparam int M      = THRESHOLD_BITS + 4;
  localparam int SUM_W  = $clog2(SYNAPSES) + 2;
  // Product of a SUM_W signed sum and a 4-bit unsigned factor.
  localparam int PROD_W = SUM_W + 5;
  localparam int ADD_W  = BATCHNORM_ADDEND_BITS;
  localparam int BN_W   = ((PROD_W > ADD_W) ? PROD_W : ADD_W) + 1;
  // Two guard bits cover u - leak - threshold + bn without overflow.
  localparam int FULL_W = ((M > BN_W) ? M : BN_W) + 2;

`ifdef LIF_SATURATE_EN
  localparam logic signed [FULL_W-1:0] U_MAX = FULL_W'((2 ** (M - 1)) - 1);
  localparam logic signed [FULL_W-1:0] U_MIN = FULL_W'(-(2 ** (M - 1)));
`endif

  // Net synaptic drive: +1 per excitatory active synapse, -1 per inhibitory.
  function automatic logic signed [SUM_W-1:0] weighted_sum(
    input logic [SYNAPSES-1:0] spikes,
    input logic [SYNAPSES-1:0] w
  );
    logic signed [SUM_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < SYNAPSES; i++) begin
      if (spikes[i]) begin
        acc = w[i] ? (acc + SUM_W'(1)) : (acc - SUM_W'(1));
      end
    end
    return acc;
  endfunction

  // Scale by factor/2 (floor via arithmetic shift) and add the signed offset.
  // The 4-bit addend is sign-extended from its bit 3 to ADD_W bits.
  function automatic logic signed [BN_W-1:0] scale_input(
    input logic signed [SUM_W-1:0] sum,
    input logic        [3:0]       factor,
    input logic        [3:0]       addend
  );
    logic signed [PROD_W-1:0] sum_x;
    logic signed [PROD_W-1:0] fac_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [3:0]        add4;
    logic signed [ADD_W-1:0]  add_x;
    sum_x = PROD_W'(sum);
    fac_x = $signed({{(PROD_W-4){1'b0}}, factor});
    prod  = sum_x * fac_x;
    add4  = addend;
    add_x = ADD_W'(add4);
    return BN_W'(prod >>> 1) + BN_W'(add_x);
  endfunction

  // Bring the full-width update back to the membrane width.
  function automatic logic signed [M-1:0] fit_membrane(
    input logic signed [FULL_W-1:0] v
  );
`ifdef LIF_SATURATE_EN
    if (v > U_MAX) begin
      return M'(U_MAX);
    end
    if (v < U_MIN) begin
      return M'(U_MIN);
    end
    return M'(v);
`else
    return M'(v);
`endif
  endfunction

  logic signed [M-1:0]      membrane_p0;
  logic                     prev_p0;

  logic signed [M-1:0]      thr_ext;
  logic                     is_spike;
  logic signed [SUM_W-1:0]  syn_sum;
  logic signed [BN_W-1:0]   bn;
  logic signed [M-1:0]      leak;
  logic signed [M-1:0]      thr_sub;
  logic signed [FULL_W-1:0] u_full;
  logic signed [M-1:0]      u_next;

  // Threshold is unsigned; the zero-extended copy is always non-negative, so
  // a signed compare against the membrane is exact.
  assign thr_ext  = $signed({4'b0000, nrn.threshold});
  assign is_spike = (membrane_p0 >= thr_ext);

  // ---- combinational update from membrane_p0 and the current inputs ----
  always_comb begin
    syn_sum = weighted_sum(nrn.inputs, nrn.weights);
    bn      = scale_input(syn_sum, nrn.batchnorm_factor, nrn.batchnorm_addend);

    // Shift 0 means "no leak", not "leak everything" (u >>> 0 would be u).
    leak = '0;
    if (nrn.shift != 3'd0) begin
      leak = membrane_p0 >>> nrn.shift;
    end

    thr_sub = '0;
    if (is_spike) begin
      thr_sub = thr_ext;
    end

    u_full = FULL_W'(membrane_p0) - FULL_W'(leak) - FULL_W'(thr_sub) + FULL_W'(bn);
    u_next = fit_membrane(u_full);
  end

  // ---- stage p0: membrane state and is_spike history ----
  always_ff @(posedge clk) begin
    if (reset) begin
      membrane_p0 <= '0;
      prev_p0     <= 1'b0;
    end else begin
      // Edge history follows is_spike every cycle, independent of enable.
      prev_p0 <= is_spike;
      if (nrn.enable) begin
        membrane_p0 <= u_next;
      end
    end
  end

  assign nrn.is_spike      = is_spike;
  assign nrn.spike_posedge = is_spike & ~prev_p0;
  assign nrn.spike_negedge = ~is_spike & prev_p0;
  assign nrn.membrane      = membrane_p0;

endmodule

// File: tb/tb_lif_neuron.sv
// Self-checking bench for lif_neuron (SYNAPSES=16, THRESHOLD_BITS=5, M=9).
// Directed scenarios with literal expectations followed by randomized cycles
// checked against an integer model of the neuron equations.
module tb_lif_neuron;
  localparam int SYN = 16;
  localparam int TB  = 5;
  localparam int M   = TB + 4;

  logic clk = 1'b0;
  logic reset;

  int total = 0;
  int bad   = 0;

  // Reference model state: membrane potential and previous is_spike.
  int m_u    = 0;
  bit m_prev = 1'b0;

  lif_neuron_if #(.SYNAPSES(SYN), .THRESHOLD_BITS(TB)) nif ();

  lif_neuron #(
    .SYNAPSES(SYN),
    .THRESHOLD_BITS(TB),
    .BATCHNORM_ADDEND_BITS(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .nrn  (nif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // floor(x / 2^k)
  function automatic int fdiv(input int x, input int k);
    int d;
    d = 1 << k;
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  function automatic int fit(input int v);
    int lo, hi, w;
    lo = -(1 << (M - 1));
    hi = (1 << (M - 1)) - 1;
`ifdef LIF_SATURATE_EN
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    w = v & ((1 << M) - 1);
    if (w > hi) w = w - (1 << M);
    return w;
`endif
  endfunction

  function automatic int model_next(input bit spk);
    int pos, neg, p, add, bn, leak, v;
    pos = $countones(nif.inputs & nif.weights);
    neg = $countones(nif.inputs & ~nif.weights);
    p   = (pos - neg) * int'(nif.batchnorm_factor);
    add = int'(nif.batchnorm_addend);
    if (add > 7) add = add - 16;
    bn   = fdiv(p, 1) + add;
    leak = (nif.shift == 3'd0) ? 0 : fdiv(m_u, int'(nif.shift));
    v    = m_u - leak - (spk ? int'(nif.threshold) : 0) + bn;
    return fit(v);
  endfunction

  task automatic set_cfg(input logic [SYN-1:0] in_v, input logic [SYN-1:0] w_v,
                         input int fac, input int add, input int sh,
                         input int thr, input logic en);
    nif.inputs           = in_v;
    nif.weights          = w_v;
    nif.batchnorm_factor = 4'(fac);
    nif.batchnorm_addend = 4'(add);
    nif.shift            = 3'(sh);
    nif.threshold        = TB'(thr);
    nif.enable           = en;
  endtask

  // One clock: advance the model, then compare every output against it.
  task automatic step(input logic rst_v, input string tag);
    int nxt;
    bit spk_pre, spk_now;
    reset   = rst_v;
    spk_pre = (m_u >= int'(nif.threshold));
    nxt     = model_next(spk_pre);
    @(posedge clk);
    #1;
    if (rst_v) begin
      m_u    = 0;
      m_prev = 1'b0;
    end else begin
      m_prev = spk_pre;
      if (nif.enable) m_u = nxt;
    end
    spk_now = (m_u >= int'(nif.threshold));
    check({tag, "_mem"}, int'(nif.membrane), m_u);
    check({tag, "_spk"}, int'(nif.is_spike), int'(spk_now));
    check({tag, "_pos"}, int'(nif.spike_posedge), int'(spk_now & ~m_prev));
    check({tag, "_neg"}, int'(nif.spike_negedge), int'(~spk_now & m_prev));
  endtask

  initial begin
    int sat3;
    reset = 1'b1;

    // Reset overrides enable with every input high.
    set_cfg(16'hFFFF, 16'hFFFF, 15, 15, 7, 31, 1'b1);
    step(1'b1, "rst0");
    step(1'b1, "rst1");
    check("rst_mem", int'(nif.membrane), 0);
    check("rst_spk", int'(nif.is_spike), 0);
    check("rst_pos", int'(nif.spike_posedge), 0);
    check("rst_neg", int'(nif.spike_negedge), 0);

    // Excitation: 0 -> 16 -> 22, one posedge pulse.
    set_cfg(16'hFFFF, 16'hFFFF, 2, 0, 4, 9, 1'b1);
    step(1'b1, "exc_r");
    step(1'b0, "exc1");
    check("exc_mem1", int'(nif.membrane), 16);
    check("exc_spk1", int'(nif.is_spike), 1);
    check("exc_pos1", int'(nif.spike_posedge), 1);
    step(1'b0, "exc2");
    check("exc_mem2", int'(nif.membrane), 22);
    check("exc_pos2", int'(nif.spike_posedge), 0);

    // Inhibition: 0 -> -16 -> -31, never fires.
    set_cfg(16'hFFFF, 16'h0000, 2, 0, 4, 9, 1'b1);
    step(1'b1, "inh_r");
    step(1'b0, "inh1");
    check("inh_mem1", int'(nif.membrane), -16);
    step(1'b0, "inh2");
    check("inh_mem2", int'(nif.membrane), -31);
    check("inh_spk2", int'(nif.is_spike), 0);

    // Hold: reach 16, then five disabled cycles.
    set_cfg(16'hFFFF, 16'hFFFF, 2, 0, 4, 9, 1'b1);
    step(1'b1, "hold_r");
    step(1'b0, "hold_up");
    nif.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, "hold");
      check("hold_mem", int'(nif.membrane), 16);
      check("hold_neg", int'(nif.spike_negedge), 0);
    end

    // Sign extension of addend 4'b1111 with leak: 0 -> -1 -> -1.
    set_cfg(16'h0000, 16'hFFFF, 2, 15, 4, 9, 1'b1);
    step(1'b1, "sx_r");
    step(1'b0, "sx1");
    check("sx_mem1", int'(nif.membrane), -1);
    step(1'b0, "sx2");
    check("sx_mem2", int'(nif.membrane), -1);
    step(1'b0, "sx3");
    check("sx_mem3", int'(nif.membrane), -1);

    // Overflow: 0 -> 120 -> 202 -> clamp 255 or wrap -233.
`ifdef LIF_SATURATE_EN
    sat3 = 255;
`else
    sat3 = -233;
`endif
    set_cfg(16'hFFFF, 16'hFFFF, 15, 0, 4, 31, 1'b1);
    step(1'b1, "sat_r");
    step(1'b0, "sat1");
    check("sat_mem1", int'(nif.membrane), 120);
    step(1'b0, "sat2");
    check("sat_mem2", int'(nif.membrane), 202);
    step(1'b0, "sat3");
    check("sat_mem3", int'(nif.membrane), sat3);

    // Threshold 0 right after reset fires immediately.
    set_cfg(16'h0000, 16'h0000, 2, 0, 0, 0, 1'b0);
    step(1'b1, "thr0_r");
    check("thr0_spk", int'(nif.is_spike), 1);
    check("thr0_mem", int'(nif.membrane), 0);

    // Randomized cycles against the model.
    step(1'b1, "rnd_r");
    for (int i = 0; i < 600; i++) begin
      set_cfg(16'($urandom()), 16'($urandom()),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
              ($urandom_range(0, 3) != 0));
      step(($urandom_range(0, 39) == 0), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
